// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N demultiplexer with valid/ready handshaking.
// Each input word goes to the channel chosen by IN_SEL, or to every channel
// when IN_BCAST is set. Every channel owns a one-entry output slot that holds
// the word until its consumer takes it. A word with an out-of-range select is
// accepted and thrown away, and a saturating counter records it.
module stream_demux #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_W-1:0]         IN_DATA,
    input  logic [SEL_W-1:0]          IN_SEL,
    input  logic                      IN_BCAST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    output logic [N_OUT*DATA_W-1:0]   OUT_DATA,
    output logic [N_OUT-1:0]          OUT_VALID,
    input  logic [N_OUT-1:0]          OUT_READY,
    output logic [CNT_W-1:0]          DROP_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // The select is widened by one bit so that the range check stays a real
    // comparison even when N_OUT == 2**SEL_W.
    localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0]  tgt_c;
    logic [N_OUT-1:0]  free_c;
    logic [N_OUT-1:0]  load_c;
    logic [N_OUT-1:0]  drain_c;
    logic              sel_legal_c;
    logic              accept_c;
    logic              drop_c;

    logic [N_OUT-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [N_OUT];
    logic [CNT_W-1:0]  drop_q;

    // Target set decode: all channels on broadcast, one-hot on a legal select, empty otherwise
    always_comb begin
        tgt_c       = '0;
        sel_legal_c = ({1'b0, IN_SEL} < N_OUT_EXT);
        if (IN_BCAST) begin
            tgt_c = '1;
        end else if (sel_legal_c) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (IN_SEL == SEL_W'(k)) begin
                    tgt_c[k] = 1'b1;
                end
            end
        end
    end

    // Handshake: ready only when every targeted slot is empty or draining this cycle
    always_comb begin
        free_c   = ~valid_q | OUT_READY;
        drain_c  = valid_q & OUT_READY;
        IN_READY = !RST && ((tgt_c & ~free_c) == '0);
        accept_c = IN_VALID && IN_READY;
        load_c   = accept_c ? tgt_c : '0;
        drop_c   = accept_c && !IN_BCAST && !sel_legal_c;
    end

    // Output slots: a load has priority over a drain, so one word per cycle can flow through
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (load_c[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= IN_DATA;
                end else if (drain_c[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Dropped-word counter, saturating at all-ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_q <= '0;
        end else if (drop_c && (drop_q != CNT_MAX)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    // Flatten slot data onto the output bus
    always_comb begin
        OUT_DATA = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            OUT_DATA[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign OUT_VALID = valid_q;
    assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux. Two builds are checked side by side: the default
// 4-channel build and a 3-channel build with a 2-bit drop counter. Both builds
// share one stimulus stream. The reference model keeps, for each channel, a
// queue of words that have been delivered to it but not yet consumed.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic       in_valid;
    logic [3:0] rdy4;
    logic [2:0] rdy3;

    logic [7:0] od4;
    logic [3:0] ov4;
    logic       ir4;
    logic [7:0] dc4;
    logic [5:0] od3;
    logic [2:0] ov3;
    logic       ir3;
    logic [1:0] dc3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_q [2][4][$];
    int         exp_drop [2];

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(2), .N_OUT(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_SEL(in_sel),
        .IN_BCAST(in_bcast), .IN_VALID(in_valid), .IN_READY(ir4),
        .OUT_DATA(od4), .OUT_VALID(ov4), .OUT_READY(rdy4), .DROP_CNT(dc4)
    );

    stream_demux #(.DATA_W(2), .N_OUT(3), .SEL_W(2), .CNT_W(2)) u_dut3 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_SEL(in_sel),
        .IN_BCAST(in_bcast), .IN_VALID(in_valid), .IN_READY(ir3),
        .OUT_DATA(od3), .OUT_VALID(ov3), .OUT_READY(rdy3), .DROP_CNT(dc3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for one build. It checks the current outputs, retires
    // the words that are consumed, and records this cycle's accept.
    task automatic model_step(input int id, input int n, input int cmax,
                              input logic [7:0] od, input logic [3:0] ov,
                              input logic [3:0] orr, input logic ir,
                              input logic [7:0] dc);
        logic [3:0] tg;
        logic       exp_ir;
        if (rst) begin
            chk($sformatf("dut%0d reset ready", id), 32'(ir), 32'd0);
            chk($sformatf("dut%0d reset valid", id), 32'(ov), 32'd0);
            chk($sformatf("dut%0d reset data", id), 32'(od), 32'd0);
            chk($sformatf("dut%0d reset drop", id), 32'(dc), 32'd0);
            for (int k = 0; k < 4; k++) exp_q[id][k].delete();
            exp_drop[id] = 0;
            return;
        end
        chk($sformatf("dut%0d drop_cnt", id), 32'(dc), 32'(exp_drop[id]));
        tg = 4'b0000;
        if (in_bcast) begin
            for (int k = 0; k < n; k++) tg[k] = 1'b1;
        end else if (int'(in_sel) < n) begin
            tg[in_sel] = 1'b1;
        end
        exp_ir = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (tg[k] && exp_q[id][k].size() != 0 && !orr[k]) exp_ir = 1'b0;
        end
        chk($sformatf("dut%0d in_ready", id), 32'(ir), 32'(exp_ir));
        for (int k = 0; k < n; k++) begin
            chk($sformatf("dut%0d valid[%0d]", id, k), 32'(ov[k]),
                32'(exp_q[id][k].size() != 0));
            if (ov[k] && exp_q[id][k].size() != 0) begin
                chk($sformatf("dut%0d data[%0d]", id, k), 32'(od[k*2 +: 2]),
                    32'(exp_q[id][k][0]));
                if (orr[k]) void'(exp_q[id][k].pop_front());
            end
        end
        if (in_valid && exp_ir) begin
            if (tg == 4'b0000) begin
                if (exp_drop[id] < cmax) exp_drop[id]++;
            end else begin
                for (int k = 0; k < n; k++) if (tg[k]) exp_q[id][k].push_back(in_data);
            end
        end
    endtask

    // Monitor: sample in mid-cycle, when inputs and registered outputs are settled
    always @(negedge clk) begin
        model_step(0, 4, 255, od4, ov4, rdy4, ir4, dc4);
        model_step(1, 3, 3, {2'b00, od3}, {1'b0, ov3}, {1'b0, rdy3}, ir3, {6'd0, dc3});
    end

    task automatic drive(input logic v, input logic [1:0] d, input logic [1:0] s,
                         input logic b, input logic [3:0] r);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_bcast = b;
        rdy4     = r;
        rdy3     = r[2:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 2'b11;
        in_sel = 2'd0;
        in_bcast = 1'b0;
        rdy4 = 4'hF;
        rdy3 = 3'h7;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // single routing, full throughput
        drive(1'b1, 2'b01, 2'd1, 1'b0, 4'hF);
        drive(1'b1, 2'b10, 2'd2, 1'b0, 4'hF);
        drive(1'b1, 2'b11, 2'd3, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // back-pressure on channel 0
        repeat (3) drive(1'b1, 2'b11, 2'd0, 1'b0, 4'b1110);
        drive(1'b1, 2'b11, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // broadcast, then broadcast blocked by a full channel 2
        drive(1'b1, 2'b10, 2'd0, 1'b1, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b1, 2'b01, 2'd2, 1'b0, 4'b1011);
        repeat (3) drive(1'b1, 2'b10, 2'd0, 1'b1, 4'b1011);
        drive(1'b1, 2'b10, 2'd0, 1'b1, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // illegal select on the 3-channel build; its 2-bit counter saturates
        for (int i = 0; i < 5; i++) drive(1'b1, 2'(i), 2'd3, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        chk("dut1 saturated drop", 32'(dc3), 32'd3);

        // asynchronous reset while channels 1 and 3 hold words
        drive(1'b1, 2'b01, 2'd1, 1'b0, 4'h0);
        drive(1'b1, 2'b10, 2'd3, 1'b0, 4'h0);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'h0);
        chk("dut0 held before reset", 32'(ov4), 32'b1010);
        #2;
        rst = 1'b1;
        #1;
        chk("dut0 async clear", 32'(ov4), 32'd0);
        chk("dut1 async clear", 32'(ov3), 32'd0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 2'b11, 2'd2, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom), 2'($urandom),
                  1'($urandom_range(0, 7) == 0), 4'($urandom));
        end
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking; successor to the combinational 4-way 2-bit demultiplexer.
- Each input word is steered to one output channel selected by SEL, or copied to all channels in broadcast mode. Each channel holds the word in a one-entry output register until its consumer accepts it.
- Sits between a single producer and N independent consumers, and absorbs consumer back-pressure without losing data.

Parameters:
- DATA_W, 2, width of each data word
- N_OUT, 4, number of output channels; must be ≥2 and ≤2**SEL_W
- SEL_W, 2, width of the select input
- CNT_W, 8, width of the dropped-word counter

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous reset, active-high
- IN_DATA  input  DATA_W  input word
- IN_SEL  input  SEL_W  destination channel index
- IN_BCAST  input  1  1 = send to all channels; IN_SEL is ignored
- IN_VALID  input  1  producer has a word
- IN_READY  output  1  block can accept a word this cycle (combinational)
- OUT_DATA  output  N_OUT*DATA_W  flattened channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- OUT_VALID  output  N_OUT  per-channel valid, registered
- OUT_READY  input  N_OUT  per-channel consumer ready
- DROP_CNT  output  CNT_W  count of words dropped because of an illegal select

Behaviour:
- Reset, asynchronous, on RST=1:
  - OUT_VALID = 0
  - OUT_DATA = 0
  - DROP_CNT = 0
  - IN_READY = 0 while RST is high
  - Reset in mid-transfer discards all held words; no partial state survives.
- Per-channel slot k:
  - Consists of a valid flag and a data register.
  - Drains when OUT_VALID[k] && OUT_READY[k].
  - Is free this cycle when !OUT_VALID[k] || OUT_READY[k]. A drain and a load in the same cycle are legal, so back-to-back traffic runs at one word per cycle.
- Target set T, combinational:
  - IN_BCAST=1: all channels.
  - IN_BCAST=0 and IN_SEL<N_OUT: the one-hot channel IN_SEL.
  - IN_BCAST=0 and IN_SEL≥N_OUT (illegal): empty set.
- IN_READY = !RST and every channel in T is free. With an empty T, IN_READY=1.
- Accept = IN_VALID && IN_READY. On accept, each channel in T loads IN_DATA and sets its valid flag at the next edge. Latency from accept to OUT_VALID is 1 cycle.
- Channels not in T are never modified by an accept and continue to drain independently.
- Broadcast is all-or-nothing: if any channel is not free, nothing is loaded and IN_READY=0. A partial broadcast is never permitted.
- Illegal select:
  - The word is accepted (consumed from the producer) and discarded.
  - DROP_CNT increments by 1 and saturates at 2**CNT_W-1; it does not wrap.
- A slot that is valid but not ready holds OUT_DATA[k] stable and OUT_VALID[k]=1 until it drains; data never changes under valid.
- OUT_DATA[k] keeps its last value after a drain. Consumers must qualify it with OUT_VALID.
- IN_VALID=0: no slot loads; slots only drain.
- No combinational path from IN_VALID to IN_READY. IN_READY depends only on IN_SEL, IN_BCAST, OUT_VALID, OUT_READY and RST.

Test Plan:
- Reset check: assert RST for 2 cycles with IN_VALID=1 -> OUT_VALID=4'b0000, OUT_DATA=0, DROP_CNT=0 and IN_READY=0 during reset; no load occurs on release.
- Single routing: with OUT_READY=4'b1111, send IN_DATA 2'b01 with SEL=1, then 2'b10 with SEL=2, then 2'b11 with SEL=3, one per cycle -> each word appears exactly one cycle after accept, on the matching channel only (OUT_VALID=4'b0010, then 4'b0100, then 4'b1000), at full throughput.
- Back-pressure: hold OUT_READY[0]=0 and send 2'b11 to SEL=0 twice -> first word is accepted and held; IN_READY=0 for the second word. Raising OUT_READY[0] drains the first word and loads the second in the same cycle.
- Broadcast: OUT_READY=4'b1111, IN_BCAST=1, IN_DATA=2'b10 -> all channels show 2'b10 with OUT_VALID=4'b1111 next cycle. Repeat with channel 2 held full -> IN_READY=0, and no channel is loaded until channel 2 drains.
- Illegal select: build with N_OUT=3 and send IN_SEL=3 five times -> each word is accepted (IN_READY=1), OUT_VALID is unchanged, DROP_CNT=5. A CNT_W=2 build with 5 drops gives DROP_CNT=3 (saturated).
- Mid-operation reset: with channels 1 and 3 holding words, pulse RST asynchronously between clock edges -> OUT_VALID clears immediately. A word sent after reset routes normally.
